// File: rtl/strng_ctrl.sv
// Controller for a self-timed ring entropy source: warm-up, synchronized sampling,
// XOR compression, word packing over valid/ready and a repetition-count health test.
module strng_ctrl #(
  parameter int LEN     = 8,
  parameter int WARMUP  = 64,
  parameter int DIV     = 4,
  parameter int WORD    = 32,
  parameter int REP_LIM = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  output logic            str_rstn,
  input  logic [LEN-1:0]  str_sout,
  output logic [WORD-1:0] rnd_data,
  output logic            rnd_valid,
  input  logic            rnd_ready,
  output logic            fail
);

  localparam int WW = $clog2(WARMUP + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WORD + 1);
  localparam int RW = $clog2(REP_LIM + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIM);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_warm    = 3'd1,
    st_collect = 3'd2,
    st_hold    = 3'd3,
    st_fail    = 3'd4
  } state_t;

  // Compresses one synchronized ring snapshot to a single entropy bit.
  function automatic logic xor_bit(input logic [LEN-1:0] v);
    return ^v;
  endfunction

  state_t          state_r, state_s;
  logic [LEN-1:0]  sync1_r, sync2_r;
  logic [WW-1:0]   warm_r, warm_s;
  logic [DW-1:0]   div_r, div_s;
  logic [BW-1:0]   bit_r, bit_s;
  logic [RW-1:0]   rep_r, rep_s;
  logic            last_r, last_s;
  logic            first_r, first_s;
  logic [WORD-1:0] data_s;
  logic            samp_s;

  // Next-state, counter and shift-register update logic.
  always_comb begin
    state_s = state_r;
    warm_s  = warm_r;
    div_s   = div_r;
    bit_s   = bit_r;
    rep_s   = rep_r;
    last_s  = last_r;
    first_s = first_r;
    data_s  = rnd_data;
    samp_s  = xor_bit(sync2_r);
    case (state_r)
      st_idle: begin
        if (en) begin
          state_s = st_warm;
          warm_s  = '0;
        end else begin
          state_s = st_idle;
        end
      end
      st_warm: begin
        if (!en) begin
          state_s = st_idle;
        end else if (warm_r == WARM_LAST) begin
          state_s = st_collect;
          div_s   = '0;
          bit_s   = '0;
          rep_s   = '0;
          first_s = 1'b1;
        end else begin
          warm_s = warm_r + WW'(1);
        end
      end
      st_collect: begin
        if (!en) begin
          state_s = st_idle;
        end else if (div_r == DIV_LAST) begin
          div_s   = '0;
          data_s  = {rnd_data[WORD-2:0], samp_s};
          bit_s   = bit_r + BW'(1);
          first_s = 1'b0;
          last_s  = samp_s;
          if (first_r || (samp_s != last_r)) begin
            rep_s = RW'(1);
          end else begin
            rep_s = rep_r + RW'(1);
          end
          // A health failure outranks delivering the word it lands in.
          if (rep_s == REP_MAX) begin
            state_s = st_fail;
          end else if (bit_r == BIT_LAST) begin
            state_s = st_hold;
          end else begin
            state_s = st_collect;
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      st_hold: begin
        if (!en) begin
          state_s = st_idle;
        end else if (rnd_ready) begin
          state_s = st_collect;
          div_s   = '0;
          bit_s   = '0;
        end else begin
          state_s = st_hold;
        end
      end
      st_fail: begin
        if (!en) begin
          state_s = st_idle;
        end else begin
          state_s = st_fail;
        end
      end
      default: begin
        state_s = st_idle;
      end
    endcase
  end

  // State, synchronizer and registered outputs; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= st_idle;
      sync1_r   <= '0;
      sync2_r   <= '0;
      warm_r    <= '0;
      div_r     <= '0;
      bit_r     <= '0;
      rep_r     <= '0;
      last_r    <= 1'b0;
      first_r   <= 1'b0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      str_rstn  <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_r   <= state_s;
      sync1_r   <= str_sout;
      sync2_r   <= sync1_r;
      warm_r    <= warm_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      rep_r     <= rep_s;
      last_r    <= last_s;
      first_r   <= first_s;
      rnd_data  <= data_s;
      rnd_valid <= (state_s == st_hold);
      str_rstn  <= (state_s == st_warm) || (state_s == st_collect) || (state_s == st_hold);
      fail      <= (state_s == st_fail);
    end
  end

endmodule

// File: tb/tb_strng_ctrl.sv
// Scoreboard bench for strng_ctrl: expected words are queued by the stimulus
// and checked by an independent monitor whenever rnd_valid rises.
module tb_strng_ctrl;

  localparam int LEN     = 8;
  localparam int WARMUP  = 4;
  localparam int DIV     = 2;
  localparam int WORD    = 8;
  localparam int REP_LIM = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            en = 1'b0;
  logic            rnd_ready = 1'b0;
  logic [LEN-1:0]  str_sout = 8'h00;
  logic            str_rstn;
  logic [WORD-1:0] rnd_data;
  logic            rnd_valid;
  logic            fail;

  strng_ctrl #(
    .LEN(LEN), .WARMUP(WARMUP), .DIV(DIV), .WORD(WORD), .REP_LIM(REP_LIM)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .str_rstn(str_rstn), .str_sout(str_sout),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .fail(fail)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge cyc equals n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // plan[e] is the value present on str_sout at rising edge e.
  logic [7:0] plan [0:4095];
  initial begin
    forever begin
      @(negedge clk);
      str_sout = plan[(cyc + 1) % 4096];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         at_e;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A byte with the requested XOR parity, varying its bit pattern with n.
  function automatic logic [7:0] pbyte(input logic b, input int n);
    case (n % 4)
      0:       return b ? 8'h0E : 8'h03;
      1:       return b ? 8'h80 : 8'h00;
      2:       return b ? 8'hF7 : 8'hFF;
      default: return b ? 8'h01 : 8'h81;
    endcase
  endfunction

  // Collection starting at edge c: sample n lands at edge c+2n and uses plan[c+2n-2].
  task automatic feed_word(input int c, input logic [7:0] bits);
    for (int n = 1; n <= 8; n++) plan[c + 2*n - 2] = pbyte(bits[8-n], n);
  endtask

  task automatic expect_word(input logic [7:0] d, input int at_e);
    exp_t e;
    e.data = d;
    e.at_e = at_e;
    exp_q.push_back(e);
  endtask

  // Monitor: checks each newly presented word and its stability while held.
  initial begin
    logic       prev_v;
    logic [7:0] cur;
    exp_t       e;
    prev_v = 1'b0;
    cur    = 8'h00;
    forever begin
      @(negedge clk);
      if (rnd_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none (edge %0d)", rnd_data, cyc);
          cur = rnd_data;
        end else begin
          e = exp_q.pop_front();
          chk("word_data", rnd_data, e.data);
          chk("word_edge", cyc, e.at_e);
          cur = e.data;
        end
      end else if (rnd_valid && prev_v) begin
        chk("hold_stable", rnd_data, cur);
      end
      prev_v = rnd_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int k2;
    int k3;
    for (int i = 0; i < 4096; i++) plan[i] = 8'h00;

    // Reset state
    at_edge(2);
    chk("rst_str_rstn", str_rstn, 1'b0);
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_data", rnd_data, 8'h00);
    chk("rst_fail", fail, 1'b0);
    rstn = 1'b1;
    at_edge(3);
    chk("idle_str_rstn", str_rstn, 1'b0);

    // Alternating parity, consumer always ready
    k = cyc + 3;
    feed_word(k + 4, 8'hAA);
    feed_word(k + 21, 8'hAA);
    expect_word(8'hAA, k + 20);
    expect_word(8'hAA, k + 37);
    rnd_ready = 1'b1;
    at_edge(k - 1);
    en = 1'b1;
    at_edge(k);
    chk("warm_str_rstn", str_rstn, 1'b1);
    at_edge(k + 19);
    chk("alt_pre_valid", rnd_valid, 1'b0);
    at_edge(k + 21);
    chk("alt_pulse_end", rnd_valid, 1'b0);
    at_edge(k + 39);
    en = 1'b0;
    at_edge(k + 40);
    chk("alt_off_str_rstn", str_rstn, 1'b0);

    // Stuck-at-zero ring trips the health test on the 8th sample
    k = cyc + 3;
    for (int e = k; e <= k + 24; e++) plan[e] = 8'h00;
    at_edge(k - 1);
    en = 1'b1;
    at_edge(k + 19);
    chk("stuck_pre_fail", fail, 1'b0);
    chk("stuck_pre_str_rstn", str_rstn, 1'b1);
    at_edge(k + 20);
    chk("stuck_fail", fail, 1'b1);
    chk("stuck_str_rstn", str_rstn, 1'b0);
    chk("stuck_valid", rnd_valid, 1'b0);
    at_edge(k + 24);
    chk("stuck_sticky", fail, 1'b1);
    en = 1'b0;
    at_edge(k + 25);
    chk("stuck_clear", fail, 1'b0);
    chk("stuck_idle_str_rstn", str_rstn, 1'b0);

    // Back-pressure: word held for 10 cycles while str_sout keeps moving
    k = cyc + 3;
    feed_word(k + 4, 8'hCA);
    for (int e = k + 19; e <= k + 29; e++) plan[e] = 8'(e * 37 + 5);
    feed_word(k + 30, 8'h35);
    expect_word(8'hCA, k + 20);
    expect_word(8'h35, k + 46);
    rnd_ready = 1'b0;
    at_edge(k - 1);
    en = 1'b1;
    for (int e = k + 20; e <= k + 29; e++) begin
      at_edge(e);
      chk("stall_valid", rnd_valid, 1'b1);
    end
    rnd_ready = 1'b1;
    at_edge(k + 30);
    chk("stall_release", rnd_valid, 1'b0);
    at_edge(k + 47);
    en = 1'b0;
    at_edge(k + 48);

    // Disable mid-collection, then disable in hold while ready is high
    k = cyc + 3;
    feed_word(k + 4, 8'h55);
    k2 = k + 13;
    feed_word(k2 + 4, 8'h96);
    expect_word(8'h96, k2 + 20);
    k3 = k2 + 25;
    feed_word(k3 + 4, 8'h3C);
    expect_word(8'h3C, k3 + 20);
    rnd_ready = 1'b0;
    at_edge(k - 1);
    en = 1'b1;
    at_edge(k + 9);
    en = 1'b0;
    at_edge(k + 10);
    chk("drop_collect_str_rstn", str_rstn, 1'b0);
    chk("drop_collect_valid", rnd_valid, 1'b0);
    at_edge(k2 - 1);
    en = 1'b1;
    at_edge(k2 + 3);
    chk("rewarm_str_rstn", str_rstn, 1'b1);
    at_edge(k2 + 19);
    chk("rewarm_pre_valid", rnd_valid, 1'b0);
    at_edge(k2 + 22);
    en = 1'b0;
    rnd_ready = 1'b1;
    at_edge(k2 + 23);
    chk("drop_hold_valid", rnd_valid, 1'b0);
    chk("drop_hold_str_rstn", str_rstn, 1'b0);
    at_edge(k3 - 1);
    en = 1'b1;
    at_edge(k3 + 21);
    chk("rewarm2_pulse_end", rnd_valid, 1'b0);
    en = 1'b0;
    at_edge(k3 + 22);

    // Synchronous reset while holding a word, en kept high
    k = cyc + 3;
    feed_word(k + 4, 8'hA5);
    expect_word(8'hA5, k + 20);
    k2 = k + 24;
    feed_word(k2 + 4, 8'h69);
    expect_word(8'h69, k2 + 20);
    rnd_ready = 1'b0;
    at_edge(k - 1);
    en = 1'b1;
    at_edge(k + 22);
    rstn = 1'b0;
    at_edge(k + 23);
    chk("srst_valid", rnd_valid, 1'b0);
    chk("srst_data", rnd_data, 8'h00);
    chk("srst_str_rstn", str_rstn, 1'b0);
    chk("srst_fail", fail, 1'b0);
    rstn = 1'b1;
    at_edge(k2);
    chk("srst_rewarm", str_rstn, 1'b1);
    at_edge(k2 + 19);
    rnd_ready = 1'b1;
    at_edge(k2 + 21);
    en = 1'b0;
    at_edge(k2 + 22);

    // Run of 7 across a word boundary passes; run of 8 across the next one fails
    k = cyc + 3;
    feed_word(k + 4, 8'h4F);
    feed_word(k + 21, 8'hE0);
    feed_word(k + 38, 8'h00);
    expect_word(8'h4F, k + 20);
    expect_word(8'hE0, k + 37);
    at_edge(k - 1);
    en = 1'b1;
    at_edge(k + 37);
    chk("run7_no_fail", fail, 1'b0);
    at_edge(k + 43);
    chk("run8_pre_fail", fail, 1'b0);
    at_edge(k + 44);
    chk("run8_fail", fail, 1'b1);
    chk("run8_str_rstn", str_rstn, 1'b0);
    at_edge(k + 45);
    en = 1'b0;
    at_edge(k + 46);
    chk("run8_clear", fail, 1'b0);

    at_edge(cyc + 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
